// File: rtl/n64adv_vdemux.sv
// rtl/n64adv_vdemux.sv - N64 video bus demultiplexer, line counter and mode detection (option: N64ADV_VDEMUX_PHASECHK_EN)
module n64adv_vdemux #(
  parameter int color_width_i = 7,
  parameter int lcnt_width = 10,
  parameter logic [lcnt_width-1:0] pal_thresh = 10'd290
) (
  input  logic                           VCLK,
  input  logic                           VRST,
  input  logic                           nVDSYNC,
  input  logic [color_width_i-1:0]       VD_i,
  output logic [4+3*color_width_i-1:0]   vdata_o,
  output logic                           vdata_valid,
  output logic [1:0]                     vinfo_o,
  output logic [lcnt_width-1:0]          line_cnt_o,
  output logic [7:0]                     phase_err_o
);

  typedef enum logic [2:0] {S_IDLE, S_R, S_G, S_B, S_DONE} state_t;

  state_t state, nextState;
  logic capSync, capR, capG, capB;

  logic [3:0]               syncReg;
  logic [color_width_i-1:0] rReg, gReg;

  logic [3:0]            prevSync;
  logic [lcnt_width-1:0] lineCnt;
  logic                  palmode, n64_480i, fieldPrev;
  logic                  hsFall, vsFall;

  // Phase state register
  always_ff @(posedge VCLK) begin
    if (VRST) state <= S_IDLE;
    else      state <= nextState;
  end

  // Next phase and slot capture strobes; a low nVDSYNC always restarts the frame
  always_comb begin
    nextState = state;
    capSync   = 1'b0;
    capR      = 1'b0;
    capG      = 1'b0;
    capB      = 1'b0;
    if (!nVDSYNC) begin
      capSync   = 1'b1;
      nextState = S_R;
    end else begin
      case (state)
        S_R:     begin capR = 1'b1; nextState = S_G;    end
        S_G:     begin capG = 1'b1; nextState = S_B;    end
        S_B:     begin capB = 1'b1; nextState = S_DONE; end
        S_DONE:  nextState = S_IDLE;
        default: nextState = S_IDLE;
      endcase
    end
  end

  // Slot capture registers for the frame being assembled
  always_ff @(posedge VCLK) begin
    if (VRST) begin
      syncReg <= 4'hF;
      rReg    <= '0;
      gReg    <= '0;
    end else begin
      if (capSync) syncReg <= VD_i[3:0];
      if (capR)    rReg    <= VD_i;
      if (capG)    gReg    <= VD_i;
    end
  end

  // Pixel word output; B is taken straight from the bus on the last slot
  always_ff @(posedge VCLK) begin
    if (VRST) begin
      vdata_o     <= {4'hF, {(3*color_width_i){1'b0}}};
      vdata_valid <= 1'b0;
    end else begin
      vdata_valid <= capB;
      if (capB) vdata_o <= {syncReg, rReg, gReg, VD_i};
    end
  end

  // Sync edges relative to the previously assembled pixel (bit3 nVSYNC, bit1 nHSYNC)
  assign hsFall = prevSync[1] & ~syncReg[1];
  assign vsFall = prevSync[3] & ~syncReg[3];

  // Line counter and video-mode detection, advanced once per assembled pixel
  always_ff @(posedge VCLK) begin
    if (VRST) begin
      prevSync   <= 4'hF;
      lineCnt    <= '0;
      line_cnt_o <= '0;
      palmode    <= 1'b0;
      n64_480i   <= 1'b0;
      fieldPrev  <= 1'b0;
    end else if (capB) begin
      prevSync <= syncReg;
      if (vsFall) begin
        line_cnt_o <= lineCnt;
        lineCnt    <= '0;
        palmode    <= (lineCnt > pal_thresh);
        n64_480i   <= (syncReg[1] != fieldPrev);
        fieldPrev  <= syncReg[1];
      end else if (hsFall && (lineCnt != {lcnt_width{1'b1}})) begin
        lineCnt <= lineCnt + 1'b1;
      end
    end
  end

  assign vinfo_o = {palmode, n64_480i};

`ifdef N64ADV_VDEMUX_PHASECHK_EN
  logic idleArmed, phaseBump;

  // A sync slot inside a frame, or a second idle slot after a finished frame, is a phase slip
  assign phaseBump = (!nVDSYNC && (state == S_R || state == S_G || state == S_B)) ||
                     (nVDSYNC && state == S_IDLE && idleArmed);

  // Saturating phase-error counter; idleArmed marks the first idle slot after S_DONE
  always_ff @(posedge VCLK) begin
    if (VRST) begin
      phase_err_o <= 8'h00;
      idleArmed   <= 1'b0;
    end else begin
      idleArmed <= (state == S_DONE) && nVDSYNC;
      if (phaseBump && (phase_err_o != 8'hFF)) phase_err_o <= phase_err_o + 8'h01;
    end
  end
`else
  assign phase_err_o = 8'h00;
`endif

endmodule

// File: tb/tb_n64adv_vdemux.sv
// tb/tb_n64adv_vdemux.sv - directed self-checking bench for n64adv_vdemux
module tb_n64adv_vdemux;

  logic        VCLK = 1'b0;
  logic        VRST = 1'b1;
  logic        nVDSYNC = 1'b1;
  logic [6:0]  VD_i = 7'h00;
  logic [24:0] vdata_o;
  logic        vdata_valid;
  logic [1:0]  vinfo_o;
  logic [9:0]  line_cnt_o;
  logic [7:0]  phase_err_o;

  int tests = 0;
  int fails = 0;
  int strobes = 0;
  int gapErr = 0;
  int lastStrobe = -1;
  int cyc = 0;

  localparam logic [24:0] RST_DATA = {4'hF, 21'h0};

  n64adv_vdemux dut (
    .VCLK(VCLK), .VRST(VRST), .nVDSYNC(nVDSYNC), .VD_i(VD_i),
    .vdata_o(vdata_o), .vdata_valid(vdata_valid), .vinfo_o(vinfo_o),
    .line_cnt_o(line_cnt_o), .phase_err_o(phase_err_o)
  );

  always #5 VCLK = ~VCLK;

  always @(posedge VCLK) cyc++;

  // strobe counter and spacing monitor
  always @(negedge VCLK) begin
    if (vdata_valid === 1'b1) begin
      if (lastStrobe >= 0 && (cyc - lastStrobe) != 4) gapErr++;
      lastStrobe = cyc;
      strobes++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic slot(input logic nvd, input logic [6:0] vd);
    @(negedge VCLK);
    nVDSYNC = nvd;
    VD_i = vd;
  endtask

  task automatic pixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
    slot(1'b0, {3'b000, s});
    slot(1'b1, r);
    slot(1'b1, g);
    slot(1'b1, b);
  endtask

  task automatic px(input logic nv, input logic nh);
    pixel({nv, 1'b1, nh, nh}, 7'h11, 7'h22, 7'h33);
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      px(1'b1, 1'b1);
      px(1'b1, 1'b0);
    end
  endtask

  task automatic do_reset;
    @(negedge VCLK);
    VRST = 1'b1;
    nVDSYNC = 1'b1;
    VD_i = 7'h00;
    @(negedge VCLK);
    @(negedge VCLK);
    VRST = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tests++; if (vdata_o !== RST_DATA) begin fails++; $display("FAIL reset_vdata got %h exp %h", vdata_o, RST_DATA); end
    tests++; if (vdata_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", vdata_valid); end
    tests++; if (vinfo_o !== 2'b00) begin fails++; $display("FAIL reset_vinfo got %b exp 00", vinfo_o); end
    tests++; if (line_cnt_o !== 10'd0) begin fails++; $display("FAIL reset_line_cnt got %0d exp 0", line_cnt_o); end
    tests++; if (phase_err_o !== 8'h00) begin fails++; $display("FAIL reset_phase_err got %h exp 00", phase_err_o); end
  endtask

  task automatic test_first_frame;
    logic [24:0] exp;
    exp = {4'hF, 7'h12, 7'h34, 7'h56};
    do_reset();
    slot(1'b0, 7'h0F);
    slot(1'b1, 7'h12);
    tests++; if (vdata_valid !== 1'b0) begin fails++; $display("FAIL first_early_valid got %b exp 0", vdata_valid); end
    tests++; if (vdata_o !== RST_DATA) begin fails++; $display("FAIL first_hold_reset got %h exp %h", vdata_o, RST_DATA); end
    slot(1'b1, 7'h34);
    slot(1'b1, 7'h56);
    @(negedge VCLK);
    tests++; if (vdata_valid !== 1'b1) begin fails++; $display("FAIL first_valid got %b exp 1", vdata_valid); end
    tests++; if (vdata_o !== exp) begin fails++; $display("FAIL first_data got %h exp %h", vdata_o, exp); end
    @(negedge VCLK);
    tests++; if (vdata_valid !== 1'b0) begin fails++; $display("FAIL first_width got %b exp 0", vdata_valid); end
    tests++; if (vdata_o !== exp) begin fails++; $display("FAIL first_hold got %h exp %h", vdata_o, exp); end
  endtask

  task automatic test_back_to_back;
    logic [24:0] exp;
    repeat (2) @(negedge VCLK);
    strobes = 0;
    gapErr = 0;
    lastStrobe = -1;
    for (int i = 0; i < 100; i++) begin
      pixel(4'hF, 7'(i), 7'(i + 1), 7'(i + 2));
    end
    exp = {4'hF, 7'd99, 7'd100, 7'd101};
    @(negedge VCLK);
    tests++; if (vdata_o !== exp) begin fails++; $display("FAIL b2b_last_data got %h exp %h", vdata_o, exp); end
    repeat (3) @(negedge VCLK);
    tests++; if (strobes !== 100) begin fails++; $display("FAIL b2b_count got %0d exp 100", strobes); end
    tests++; if (gapErr !== 0) begin fails++; $display("FAIL b2b_spacing got %0d bad gaps exp 0", gapErr); end
  endtask

  task automatic test_phase;
    logic [24:0] exp;
    logic [7:0]  expErr1, expErr2;
`ifdef N64ADV_VDEMUX_PHASECHK_EN
    expErr1 = 8'd1;
    expErr2 = 8'd2;
`else
    expErr1 = 8'd0;
    expErr2 = 8'd0;
`endif
    exp = {4'hA, 7'h01, 7'h02, 7'h03};
    do_reset();
    strobes = 0;
    lastStrobe = -1;
    slot(1'b0, 7'h0F);
    slot(1'b1, 7'h12);
    slot(1'b0, 7'h0A);
    slot(1'b1, 7'h01);
    slot(1'b1, 7'h02);
    slot(1'b1, 7'h03);
    @(negedge VCLK);
    tests++; if (vdata_valid !== 1'b1) begin fails++; $display("FAIL phase_valid_k6 got %b exp 1", vdata_valid); end
    tests++; if (vdata_o !== exp) begin fails++; $display("FAIL phase_data got %h exp %h", vdata_o, exp); end
    tests++; if (phase_err_o !== expErr1) begin fails++; $display("FAIL phase_err_slot got %0d exp %0d", phase_err_o, expErr1); end
    @(negedge VCLK);
    tests++; if (strobes !== 1) begin fails++; $display("FAIL phase_strobes got %0d exp 1", strobes); end
    @(negedge VCLK);
    tests++; if (phase_err_o !== expErr2) begin fails++; $display("FAIL phase_err_idle got %0d exp %0d", phase_err_o, expErr2); end
  endtask

  task automatic test_lines;
    do_reset();
    px(1'b0, 1'b0);
    lines(263);
    px(1'b0, 1'b1);
    @(negedge VCLK);
    tests++; if (line_cnt_o !== 10'd263) begin fails++; $display("FAIL ntsc_cnt1 got %0d exp 263", line_cnt_o); end
    tests++; if (vinfo_o !== 2'b01) begin fails++; $display("FAIL ntsc_info1 got %b exp 01", vinfo_o); end
    lines(263);
    px(1'b0, 1'b0);
    @(negedge VCLK);
    tests++; if (line_cnt_o !== 10'd263) begin fails++; $display("FAIL ntsc_cnt2 got %0d exp 263", line_cnt_o); end
    tests++; if (vinfo_o !== 2'b01) begin fails++; $display("FAIL ntsc_info2 got %b exp 01", vinfo_o); end
    lines(313);
    px(1'b0, 1'b0);
    @(negedge VCLK);
    tests++; if (line_cnt_o !== 10'd313) begin fails++; $display("FAIL pal_cnt1 got %0d exp 313", line_cnt_o); end
    tests++; if (vinfo_o !== 2'b10) begin fails++; $display("FAIL pal_info1 got %b exp 10", vinfo_o); end
    lines(313);
    px(1'b0, 1'b0);
    @(negedge VCLK);
    tests++; if (line_cnt_o !== 10'd313) begin fails++; $display("FAIL pal_cnt2 got %0d exp 313", line_cnt_o); end
    tests++; if (vinfo_o !== 2'b10) begin fails++; $display("FAIL pal_info2 got %b exp 10", vinfo_o); end
  endtask

  task automatic test_saturate;
    do_reset();
    px(1'b0, 1'b0);
    lines(1100);
    px(1'b0, 1'b0);
    @(negedge VCLK);
    tests++; if (line_cnt_o !== 10'd1023) begin fails++; $display("FAIL sat_cnt got %0d exp 1023", line_cnt_o); end
    tests++; if (vinfo_o !== 2'b10) begin fails++; $display("FAIL sat_info got %b exp 10", vinfo_o); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    px(1'b0, 1'b0);
    lines(300);
    px(1'b0, 1'b1);
    @(negedge VCLK);
    tests++; if (vinfo_o !== 2'b11) begin fails++; $display("FAIL mid_pre_info got %b exp 11", vinfo_o); end
    tests++; if (line_cnt_o !== 10'd300) begin fails++; $display("FAIL mid_pre_cnt got %0d exp 300", line_cnt_o); end
    lines(3);
    slot(1'b0, 7'h0F);
    slot(1'b1, 7'h12);
    @(negedge VCLK);
    VRST = 1'b1;
    nVDSYNC = 1'b1;
    VD_i = 7'h34;
    @(negedge VCLK);
    tests++; if (vdata_o !== RST_DATA) begin fails++; $display("FAIL mid_vdata got %h exp %h", vdata_o, RST_DATA); end
    tests++; if (vdata_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", vdata_valid); end
    tests++; if (vinfo_o !== 2'b00) begin fails++; $display("FAIL mid_vinfo got %b exp 00", vinfo_o); end
    tests++; if (line_cnt_o !== 10'd0) begin fails++; $display("FAIL mid_line_cnt got %0d exp 0", line_cnt_o); end
    tests++; if (phase_err_o !== 8'h00) begin fails++; $display("FAIL mid_phase_err got %h exp 00", phase_err_o); end
    VRST = 1'b0;
    strobes = 0;
    lastStrobe = -1;
    VD_i = 7'h56;
    repeat (3) @(negedge VCLK);
    tests++; if (strobes !== 0) begin fails++; $display("FAIL mid_no_strobe got %0d exp 0", strobes); end
    px(1'b1, 1'b1);
    px(1'b1, 1'b0);
    px(1'b0, 1'b0);
    @(negedge VCLK);
    tests++; if (line_cnt_o !== 10'd1) begin fails++; $display("FAIL mid_restart_cnt got %0d exp 1", line_cnt_o); end
    tests++; if (vinfo_o !== 2'b00) begin fails++; $display("FAIL mid_restart_info got %b exp 00", vinfo_o); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_phase();
    test_lines();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/n64adv_vdemux.md
# n64adv_vdemux

Front-end demultiplexer between the N64 video pins and the picture processing unit. It recovers 4-cycle pixel frames from the multiplexed 7-bit bus, using nVDSYNC as the frame marker, and emits one parallel sync+RGB word per pixel with a valid strobe. It also counts lines per frame and derives the video-mode info bits (PAL/NTSC, 240p/480i) that feed the InfoSet path.

## Interface
- `color_width_i`, default 7: width of one colour sample on `VD_i`.
- `lcnt_width`, default 10: width of the line counter.
- `pal_thresh`, default 10'd290: a frame with more lines than this is PAL.
- `VCLK`, input, 1: video clock; the only clock in the block.
- `VRST`, input, 1: synchronous, active-high reset, sampled on posedge `VCLK`.
- `nVDSYNC`, input, 1: low marks the sync slot of a pixel frame.
- `VD_i`, input, `color_width_i`: multiplexed sync/R/G/B bus.
- `vdata_o`, output, 4+3*`color_width_i`: pixel word `{nVSYNC,nCLAMP,nHSYNC,nCSYNC,R,G,B}`.
- `vdata_valid`, output, 1: one-cycle strobe; `vdata_o` is new in this cycle.
- `vinfo_o`, output, 2: `{palmode, n64_480i}`.
- `line_cnt_o`, output, `lcnt_width`: line count of the last complete frame.
- `phase_err_o`, output, 8: saturating phase-error count (see Configuration).

## Operation
- Phase FSM with states S_IDLE, S_R, S_G, S_B, S_DONE.
  - Any state, `nVDSYNC`=0: capture `VD_i[3:0]` as the sync nibble, go to S_R. This rule has priority over all others.
  - S_R: capture R, go to S_G. S_G: capture G, go to S_B. S_B: capture B, go to S_DONE.
  - S_DONE, `nVDSYNC`=1: go to S_IDLE.
  - In S_R, S_G and S_B, `nVDSYNC`=1 is expected. The slot is taken as colour data.
- Output register: in the cycle after the B capture, `vdata_o` takes `{sync,R,G,B}` and `vdata_valid`=1. `vdata_o` holds its value otherwise.
- A pixel interrupted by `nVDSYNC`=0 in S_R, S_G or S_B is discarded. No strobe is issued for it and the new frame starts.
- Line counting applies to assembled pixels only:
  - On a falling edge of `nHSYNC` (1 in the previous pixel, 0 in this one), `line_cnt` increments and saturates at all-ones.
  - On a falling edge of `nVSYNC`:
    - `line_cnt_o` ← `line_cnt`, then `line_cnt` ← 0.
    - `palmode` ← (`line_cnt` > `pal_thresh`).
    - `field` ← `nHSYNC` of this pixel.
    - `n64_480i` ← (`field` ≠ `field_prev`); then `field_prev` ← `field`.
  - A simultaneous `nHSYNC` and `nVSYNC` falling edge is treated as a vsync: the counter clears and the hsync is not counted.
- Reset values:
  - `vdata_o` = `{4'hF, 0}`, so the syncs are inactive.
  - `vdata_valid`=0, `vinfo_o`=0, `line_cnt_o`=0, `phase_err_o`=0.
  - FSM in S_IDLE; `field_prev`=0; the stored previous-pixel sync bits are 4'hF.
- Reset in the middle of a pixel drops that pixel. The first strobe after reset requires a full `nVDSYNC`-low frame.

## Timing
- Latency: sync slot at cycle k; R, G and B at k+1 to k+3. `vdata_valid` is high at k+4 only.
- The earliest next frame has its sync slot at k+4; its strobe is at k+8. Back-to-back frames give one strobe every 4 cycles.
- `vinfo_o` and `line_cnt_o` update in the same cycle as the strobe of the pixel carrying the `nVSYNC` falling edge.
- Every output is registered. No combinational path runs from the inputs to the outputs.

## Configuration
- `N64ADV_VDEMUX_PHASECHK_EN` defined:
  - `phase_err_o` increments, saturating at 8'hFF, when `nVDSYNC`=0 arrives in S_R, S_G or S_B.
  - It also increments when `nVDSYNC` stays high for a second consecutive cycle in S_IDLE after S_DONE, i.e. 2 or more idle slots.
  - The count clears only on `VRST`.
- Not defined: `phase_err_o` is tied to 8'h00 and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset, then one frame: sync=4'hF, R=7'h12, G=7'h34, B=7'h56 → at k+4 `vdata_valid`=1 and `vdata_o`={4'hF,7'h12,7'h34,7'h56}; 1 cycle wide. Before that frame, `vdata_o` holds its reset value.
- Continuous frames for 100 pixels → exactly 100 strobes, spaced 4 cycles apart.
- `nVDSYNC`=0 at k+2 (S_G) → no strobe for the first frame; the new frame strobes at k+6. With the macro, `phase_err_o`=1; without it, 0.
- 263 hsync edges per vsync on two successive frames, field alternating 0/1 → `line_cnt_o`=263, `vinfo_o`=2'b01. Repeat with 313 lines and the same field each frame → `vinfo_o`=2'b10.
- `VRST` asserted at k+2 → all outputs return to their reset values next cycle. No strobe occurs for the interrupted pixel; `line_cnt` restarts from 0.
- Drive 1100 hsync edges with no vsync, then one vsync → `line_cnt_o`=1023 (saturated).
